// File: rtl/pool_pkg.sv
// Shared FP16 constants, pooling FSM state type and NaN helper for the
// max-pooling datapath.
package pool_pkg;
  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } pool_state_t;

  function automatic logic fp16_is_nan(input logic [FP16_W-1:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
  endfunction
endpackage

// File: rtl/fp16_gt.sv
// Combinational FP16 a > b in sign-magnitude order; signed zeros are equal,
// and any NaN operand forces 0.
module fp16_gt
  import pool_pkg::*;
(
  input  logic [FP16_W-1:0] a_i,
  input  logic [FP16_W-1:0] b_i,
  output logic              gt_o
);
  logic [FP16_W-2:0] mag_a;
  logic [FP16_W-2:0] mag_b;

  always_comb begin
    mag_a = a_i[FP16_W-2:0];
    mag_b = b_i[FP16_W-2:0];
    gt_o  = 1'b0;
    if (fp16_is_nan(a_i) || fp16_is_nan(b_i)) begin
      gt_o = 1'b0;
    end else if ((mag_a == '0) && (mag_b == '0)) begin
      gt_o = 1'b0;
    end else if (a_i[FP16_W-1] != b_i[FP16_W-1]) begin
      gt_o = !a_i[FP16_W-1];
    end else if (!a_i[FP16_W-1]) begin
      gt_o = mag_a > mag_b;
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      gt_o = mag_a < mag_b;
    end
  end
endmodule

// File: rtl/pool_max_ch.sv
// CH-lane streaming FP16 max pool; result registered 1 cycle after the final
// beat. Only a final beat stalls, and only while an undrained result is held.
module pool_max_ch
  import pool_pkg::*;
#(
  parameter int CH      = 8,
  parameter int WIN_MAX = 169,
  parameter int CNT_W   = $clog2(WIN_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     win_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*FP16_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*FP16_W-1:0] out_data,
  output logic                 busy
);
  localparam logic [CNT_W-1:0] WIN_MAX_C = CNT_W'(WIN_MAX);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  pool_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [CNT_W-1:0] len_eff, cnt_inc;
  logic [CH-1:0][FP16_W-1:0] in_lane, acc_q, acc_d, lane_acc, res_lane;
  logic [CH-1:0][FP16_W-1:0] out_data_q, out_data_d;
  logic [CH-1:0] nan_q, nan_d, lane_nan, gt_lane;
  logic out_valid_q, out_valid_d;
  logic final_beat, accept;

  assign in_lane = in_data;

  for (genvar g = 0; g < CH; g++) begin : g_lane
    fp16_gt u_gt (
      .a_i  (in_lane[g]),
      .b_i  (acc_q[g]),
      .gt_o (gt_lane[g])
    );
    // First beat of a window seeds the lane; later beats keep the larger value.
    assign lane_acc[g] = ((state_q == IDLE) || gt_lane[g]) ? in_lane[g] : acc_q[g];
    assign lane_nan[g] = fp16_is_nan(in_lane[g]) || ((state_q == ACC) && nan_q[g]);
    assign res_lane[g] = lane_nan[g] ? FP16_QNAN : lane_acc[g];
  end

  always_comb begin
    if (win_len == '0) begin
      len_eff = ONE_C;
    end else if (win_len > WIN_MAX_C) begin
      len_eff = WIN_MAX_C;
    end else begin
      len_eff = win_len;
    end
    cnt_inc    = cnt_q + ONE_C;
    final_beat = (state_q == IDLE) ? (len_eff == ONE_C) : (cnt_inc == len_q);
    in_ready   = !rst && !(final_beat && out_valid_q && !out_ready);
    accept     = in_valid && in_ready;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_d       = acc_q;
    nan_d       = nan_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    if (accept) begin
      acc_d = lane_acc;
      nan_d = lane_nan;
      if (state_q == IDLE) begin
        len_d   = len_eff;
        cnt_d   = ONE_C;
        state_d = ACC;
      end else begin
        cnt_d = cnt_inc;
      end
      if (final_beat) begin
        out_valid_d = 1'b1;
        out_data_d  = res_lane;
        nan_d       = '0;
        cnt_d       = '0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      nan_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      nan_q       <= nan_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == ACC);
endmodule

// File: tb/tb_pool_max_ch.sv
// Directed bench for pool_max_ch: hand-computed per-lane maxima, latency,
// backpressure, window-length boundaries and mid-window reset.
module tb_pool_max_ch;
  localparam int CH = 8;
  localparam int W  = CH * 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   win_len;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] res_q[$];

  pool_max_ch #(.CH(CH), .WIN_MAX(169)) dut (
    .clk       (clk),
    .rst       (rst),
    .win_len   (win_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Handshake seen at a negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) res_q.push_back(out_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [W-1:0] d, input logic [7:0] len);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    win_len  = len;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic get_res(input string tag, input logic [W-1:0] exp);
    int n;
    logic [W-1:0] got;
    n = 0;
    in_valid = 1'b0;
    while (res_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    got = {W{1'b1}};
    if (res_q.size() != 0) got = res_q.pop_front();
    chk(tag, got, exp);
  endtask

  task automatic no_extra(input string tag);
    idle(3);
    chk(tag, W'(res_q.size()), W'(0));
  endtask

  function automatic logic [W-1:0] big_beat(input int k);
    logic [15:0] m;
    m = (k == 100) ? 16'h5000 : 16'h3C00;
    return {{6{m}}, 16'h8000 | 16'(k), 16'(k)};
  endfunction

  initial begin
    logic [W-1:0] r1, r2;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; win_len = 8'd4; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;

    // Mixed lanes: positives, negatives, denormals, infinities, zeros.
    put(128'h7BFF_0000_C400_7C00_0001_BC00_4200_3C00, 8'd4);
    chk("t1_busy", W'(busy), W'(1));
    put(128'h7BFE_0000_C200_4000_0000_C000_4000_4000, 8'd4);
    put(128'h0400_0000_C500_0000_03FF_3800_3C00_3800, 8'd4);
    chk("t1_early_vld", W'(out_valid), W'(0));
    put(128'hFBFF_0000_C300_FC00_0200_B800_3800_4200, 8'd4);
    in_valid = 1'b0;
    chk("t1_latency", W'(out_valid), W'(1));
    chk("t1_busy_end", W'(busy), W'(0));
    get_res("t1_max", 128'h7BFF_0000_C200_7C00_03FF_3800_4200_4200);
    no_extra("t1_extra");

    // Signed zero keeps the first zero; all -inf stays -inf.
    put(128'hFC00_FC00_FC00_FC00_BC00_BC00_BC00_BC00, 8'd4);
    put(128'hFC00_FC00_FC00_FC00_8000_8000_8000_8000, 8'd4);
    put(128'hFC00_FC00_FC00_FC00_0000_0000_0000_0000, 8'd4);
    put(128'hFC00_FC00_FC00_FC00_C000_C000_C000_C000, 8'd4);
    get_res("t2_zero_inf", 128'hFC00_FC00_FC00_FC00_8000_8000_8000_8000);

    // NaN on lane 2, then a clean window must not inherit it.
    put({8{16'h3C00}}, 8'd3);
    put(128'h4000_4000_4000_4000_4000_7C01_4000_4000, 8'd3);
    put({8{16'h3800}}, 8'd3);
    get_res("t3_nan", 128'h4000_4000_4000_4000_4000_7E00_4000_4000);
    put({8{16'h3800}}, 8'd3);
    put({8{16'h3C00}}, 8'd3);
    put({8{16'h3400}}, 8'd3);
    get_res("t3_after_nan", {8{16'h3C00}});
    no_extra("t3_extra");

    // Backpressure: second window's final beat waits for the drain.
    r1 = {8{16'h4000}};
    r2 = {8{16'hBC00}};
    out_ready = 1'b0;
    put({8{16'h3C00}}, 8'd2);
    put({8{16'h4000}}, 8'd2);
    put({8{16'hC000}}, 8'd2);
    in_data = {8{16'hBC00}};
    @(negedge clk);
    chk("t4_rdy_low", W'(in_ready), W'(0));
    chk("t4_busy", W'(busy), W'(1));
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_stall", W'(in_ready), W'(0));
      chk("t4_hold", out_data, r1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    put({8{16'hBC00}}, 8'd2);
    get_res("t4_res1", r1);
    get_res("t4_res2", r2);
    no_extra("t4_extra");

    // win_len 0 and 1: every beat is its own window.
    put({8{16'h1111}}, 8'd0);
    put({8{16'h2222}}, 8'd1);
    put({8{16'h3333}}, 8'd0);
    in_valid = 1'b0;
    chk("t5_busy", W'(busy), W'(0));
    get_res("t5_len0", {8{16'h1111}});
    get_res("t5_len1", {8{16'h2222}});
    get_res("t5_len0b", {8{16'h3333}});
    no_extra("t5_extra");

    // Longest window, then an oversize length clamped to the same size.
    for (int k = 1; k <= 168; k++) put(big_beat(k), 8'd169);
    chk("t6_busy", W'(busy), W'(1));
    chk("t6_no_early", W'(res_q.size()), W'(0));
    put(big_beat(169), 8'd169);
    get_res("t6_169", {{6{16'h5000}}, 16'h8001, 16'h00A9});
    no_extra("t6_extra");
    for (int k = 1; k <= 169; k++) put(big_beat(k), 8'd200);
    get_res("t6_clamp", {{6{16'h5000}}, 16'h8001, 16'h00A9});
    no_extra("t6_clamp_extra");

    // Reset mid-window discards the partial sums.
    put({8{16'h7000}}, 8'd4);
    put({8{16'h7000}}, 8'd4);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_rdy", W'(in_ready), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t7_vld", W'(out_valid), W'(0));
    chk("t7_busy", W'(busy), W'(0));
    put({8{16'h3C00}}, 8'd4);
    put({8{16'h4000}}, 8'd4);
    put({8{16'h3800}}, 8'd4);
    put({8{16'h3400}}, 8'd4);
    get_res("t7_after_rst", {8{16'h4000}});
    no_extra("t7_extra");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
